// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester mux arbiter: FSM encoding and
// hold-counter width.
package mux_arb_pkg;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;
endpackage

// File: rtl/mux2x1.sv
// One-bit 2:1 mux leg; the arbiter replicates it across the data width.
module mux2x1 (
  output logic y,
  input  logic in1,
  input  logic in0,
  input  logic sel
);
  assign y = sel ? in1 : in0;
endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter with bounded hold time, registered grants, and a
// registered shared data path steered by the current grant.
module mux2_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ptr_q, ptr_d;
  logic               gnt0_q, gnt1_q, sel_q, vld_q;
  logic               sel_d, vld_d;
  logic [WIDTH-1:0]   dout_q, mux_y;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      // ptr_q=1 means requester 1 was served last, so a tie goes to 0
      IDLE: begin
        if (req0 && (!req1 || ptr_q)) state_d = GNT0;
        else if (req1)                state_d = GNT1;
      end
      GNT0: begin
        if (req0) begin
          if (cnt_q == HOLD_MAX && req1) state_d = GNT1;
        end else if (req1) state_d = GNT1;
        else               state_d = IDLE;
      end
      GNT1: begin
        if (req1) begin
          if (cnt_q == HOLD_MAX && req0) state_d = GNT0;
        end else if (req0) state_d = GNT0;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = (state_d == IDLE) ? '0 : CNT_W'(1);
      if (state_d == GNT0) ptr_d = 1'b0;
      if (state_d == GNT1) ptr_d = 1'b1;
    end else if (state_q != IDLE) begin
      cnt_d = (cnt_q == HOLD_MAX) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    end

    sel_d = (state_d == GNT1) ? 1'b1 : (state_d == GNT0) ? 1'b0 : sel_q;
    vld_d = (gnt0_q & req0) | (gnt1_q & req1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux2x1 u_mux (
      .y   (mux_y[i]),
      .in1 (din1[i]),
      .in0 (din0[i]),
      .sel (gnt1_q)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= (state_d == GNT0);
      gnt1_q  <= (state_d == GNT1);
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      if (vld_d) dout_q <= mux_y;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = vld_q;
endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: directed scenarios plus random traffic, all checked
// every cycle against an owner/streak model of the arbitration rules.
module tb_mux2_arbiter;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] din0 = '0, din1 = '0;
  logic             gnt0, gnt1, sel, dout_valid;
  logic [WIDTH-1:0] dout;

  mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .din0(din0), .din1(din1), .gnt0(gnt0), .gnt1(gnt1),
    .sel(sel), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // model: owner -1 = nobody, streak = cycles held since (re)start
  int               owner, streak, last;
  logic             m_sel, m_valid;
  logic [WIDTH-1:0] m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; streak = 0; last = 1;
    m_sel = 1'b0; m_valid = 1'b0; m_dout = '0;
  endtask

  task automatic model_step();
    logic [1:0] r;
    int nxt, oth;
    if (!rst_n) begin model_reset(); return; end
    r = {req1, req0};
    if (owner >= 0 && r[owner]) begin
      m_valid = 1'b1;
      m_dout  = (owner == 1) ? din1 : din0;
    end else m_valid = 1'b0;
    if (owner < 0) begin
      if (r == 2'b11)    nxt = (last == 1) ? 0 : 1;
      else if (r[0])     nxt = 0;
      else if (r[1])     nxt = 1;
      else               nxt = -1;
    end else begin
      oth = 1 - owner;
      if (r[owner]) nxt = (streak >= MAX_HOLD && r[oth]) ? oth : owner;
      else          nxt = r[oth] ? oth : -1;
    end
    if (nxt != owner) begin
      streak = (nxt < 0) ? 0 : 1;
      if (nxt >= 0) last = nxt;
    end else if (owner >= 0) streak = (streak % MAX_HOLD) + 1;
    if (nxt >= 0) m_sel = (nxt == 1);
    owner = nxt;
  endtask

  always @(negedge clk) begin
    chk("gnt0", {31'd0, gnt0}, {31'd0, owner == 0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, owner == 1});
    chk("sel", {31'd0, sel}, {31'd0, m_sel});
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_valid});
    chk("dout", {24'd0, dout}, {24'd0, m_dout});
  end

  // apply inputs, take one edge, leave time at edge+1
  task automatic step(input logic r0, input logic r1,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    req0 = r0; req1 = r1; din0 = d0; din1 = d1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    model_reset();
    // reset with both requesting
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) begin @(posedge clk); model_step(); end
    #1;
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    #3 rst_n = 1'b1;
    #1 chk("rel_no_change", {31'd0, gnt0}, 32'd0);
    step(1, 1, 8'h11, 8'h22);
    chk("first_tie_gnt0", {31'd0, gnt0}, 32'd1);
    chk("first_tie_sel", {31'd0, sel}, 32'd0);

    // single requester 1
    step(0, 0, 8'h00, 8'h00);
    step(0, 1, 8'h00, 8'hA5);
    chk("single_gnt1", {31'd0, gnt1}, 32'd1);
    step(0, 1, 8'h00, 8'hA5);
    chk("single_dout", {24'd0, dout}, 32'hA5);
    chk("single_valid", {31'd0, dout_valid}, 32'd1);

    // fairness: 4 and 4 alternation, requester 0 first
    step(0, 0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 8'(i), 8'(i + 100));
      chk("fair_gnt0", {31'd0, gnt0}, ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
    end

    // sole holder keeps the grant across counter restarts
    step(0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'(i + 1), 8'h00);
      chk("sole_gnt0", {31'd0, gnt0}, 32'd1);
    end

    // handover with no idle cycle
    step(0, 1, 8'h00, 8'h5C);
    chk("handover_gnt1", {31'd0, gnt1}, 32'd1);
    chk("handover_gnt0", {31'd0, gnt0}, 32'd0);

    // asynchronous reset during GNT1
    step(0, 1, 8'h00, 8'h5D);
    #2 rst_n = 1'b0; model_reset();
    #1 chk("async_gnt1", {31'd0, gnt1}, 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); model_step();
    #3 rst_n = 1'b1;
    #1;
    step(1, 1, 8'h33, 8'h44);
    chk("post_rst_gnt0", {31'd0, gnt0}, 32'd1);

    // random traffic with occasional mid-cycle resets
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
           8'($urandom), 8'($urandom));
      if (i % 97 == 50) begin
        #2 rst_n = 1'b0; model_reset();
        #1 chk("rand_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        @(posedge clk); model_step();
        #3 rst_n = 1'b1;
        #1;
      end
    end

    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each requester path.
REQ-002 SHALL have parameter MAX_HOLD, default 4, maximum consecutive grant cycles while the other side is requesting; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req0  input  1  requester 0 wants the shared mux path.
REQ-006 SHALL have port req1  input  1  requester 1 wants the shared mux path.
REQ-007 SHALL have port din0  input  WIDTH  requester 0 data, mux in0 leg.
REQ-008 SHALL have port din1  input  WIDTH  requester 1 data, mux in1 leg.
REQ-009 SHALL have port gnt0  output  1  registered grant to requester 0.
REQ-010 SHALL have port gnt1  output  1  registered grant to requester 1.
REQ-011 SHALL have port sel  output  1  registered mux select; 1 selects in1/din1, 0 selects in0/din0.
REQ-012 SHALL have port dout  output  WIDTH  registered selected data.
REQ-013 SHALL have port dout_valid  output  1  dout holds data from a granted, requesting source.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, GNT0, GNT1; gnt0=1 only in GNT0, gnt1=1 only in GNT1; never both.
REQ-015 SHALL drive sel=1 in GNT1, sel=0 in GNT0, and hold the previous sel in IDLE.
REQ-016 IDLE: req0 only -> GNT0; req1 only -> GNT1; both -> the side not recorded in the last-served pointer; neither -> stay IDLE.
REQ-017 SHALL update last-served pointer to 0 on entry to GNT0 and to 1 on entry to GNT1; the pointer resets to 1, so requester 0 wins the first tie.
REQ-018 GNTn with reqn=1: stay, increment a 4-bit hold counter; when counter reaches MAX_HOLD and the other req=1 -> move directly to the other grant state.
REQ-019 GNTn with reqn=1, counter at MAX_HOLD, other req=0: stay in GNTn and restart the counter at 1.
REQ-020 GNTn with reqn=0: other req=1 -> other grant state; else -> IDLE; a dropped request releases the grant the next edge.
REQ-021 SHALL reset the hold counter to 1 on every entry into a grant state and to 0 in IDLE.
REQ-022 Grant latency: request sampled at edge k, grant visible after edge k; no combinational path from req to gnt.
REQ-023 SHALL register dout <= (gnt1 ? din1 : din0) and dout_valid <= (gnt0&req0)|(gnt1&req1) each edge; dout latency one cycle after the granted cycle.
REQ-024 When dout_valid=0, dout SHALL hold its previous value.
REQ-025 Simultaneous req drop by the owner and rise by the other in the same cycle SHALL switch with no IDLE cycle.

Reset
REQ-026 While rst_n=0: state=IDLE, gnt0=0, gnt1=0, sel=0, dout=0, dout_valid=0, hold counter=0, pointer=1, regardless of clk.
REQ-027 Reset assertion mid-grant SHALL drop grants immediately (asynchronously); after release the first tie goes to requester 0.
REQ-028 Deassertion of rst_n SHALL take effect at the first rising clk edge after release; no outputs change on the release itself.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and counter width constant in shared package mux_arb_pkg.
REQ-030 SHALL build the data path from one sub-module, mux2x1, instantiated WIDTH times via generate with port order (y, in1, in0, sel), driven by gnt1.

Verification
REQ-031 Reset: rst_n=0 with req0=req1=1 -> all outputs 0; release -> gnt0=1 after next edge, sel=0.
REQ-032 Single requester: req1=1 only, din1=8'hA5 -> gnt1=1 one edge later, then dout=8'hA5, dout_valid=1 the edge after.
REQ-033 Fairness: req0=req1=1 continuously, MAX_HOLD=4 -> grant alternates 4 cycles gnt0, 4 cycles gnt1, repeating.
REQ-034 Sole holder: req0=1 for 10 cycles, req1=0 -> gnt0 stays 1 all 10 cycles, no gap at counter restart.
REQ-035 Handover: in GNT0 drop req0 and raise req1 in the same cycle -> gnt1=1 next edge, no IDLE cycle, no overlap.
REQ-036 Reset mid-operation: assert rst_n=0 during GNT1 between edges -> gnt1=0 immediately; after release with both requesting, gnt0 wins.
